// File: rtl/bmp_body_writer_pkg.sv
// Shared types and constants for the BMP output stages (header and body).
// Package name bmp_pkg is imported by both stages so the row padding rule
// is computed in exactly one place.
package bmp_pkg;

    // Body writer control states.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_WR_B,
        S_WR_G,
        S_WR_R,
        S_PAD,
        S_ROW_END,
        S_DONE
    } bmp_state_t;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_ROW_ALIGN = 4;

    // Zero bytes needed to bring a row of w 24-bit pixels up to a 4-byte
    // boundary. Since 3w + (w & 3) is always a multiple of 4, the pad is
    // simply the low two bits of the pixel count.
    function automatic logic [1:0] bmp_pad(input logic [10:0] w);
        logic [10:0] mask;
        mask = 11'(BMP_ROW_ALIGN - 1);
        return 2'(w & mask);
    endfunction

endpackage

// File: rtl/bmp_body_writer_byte_wr.sv
// bmp_byte_wr: stall-aware single-byte write port into the BMP output memory.
// Owns the output byte address counter and the addr/wren/wrdata outputs.
// Optional macro BMP_BODY_BYTE_COUNT_EN adds a running count of accepted
// writes on byte_count.
module bmp_byte_wr
    import bmp_pkg::*;
#(
    parameter int HDR_BYTES = BMP_HDR_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        wr_req,
    input  logic [7:0]  wr_byte,
    input  logic        wr_wait,
    output logic        accept,
    output logic [23:0] addr,
    output logic        wren,
    output logic [15:0] wrdata
`ifdef BMP_BODY_BYTE_COUNT_EN
    ,
    output logic [23:0] byte_count
`endif
);

    // The requesting FSM holds its state while stalled, so the write
    // strobe and byte are stable for as long as wr_wait stays high.
    assign wren   = wr_req;
    assign wrdata = {8'h00, wr_byte};
    assign accept = wr_req && !wr_wait;

    // Address counter: restarts at the first pixel-array byte on each job,
    // steps once per accepted byte, and wraps modulo 2^24.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= 24'd0;
        end else if (load) begin
            addr <= 24'(HDR_BYTES);
        end else if (accept) begin
            addr <= addr + 24'd1;
        end
    end

`ifdef BMP_BODY_BYTE_COUNT_EN
    // Count of accepted bytes in the current job, pad bytes included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_count <= 24'd0;
        end else if (load) begin
            byte_count <= 24'd0;
        end else if (accept) begin
            byte_count <= byte_count + 24'd1;
        end
    end
`endif

endmodule

// File: rtl/bmp_body_writer.sv
// bmp_body_writer: copies a crop window of the RGB frame buffer into the BMP
// pixel array, bottom row first, BGR byte order, rows zero-padded to 4 bytes.
// One pixel is fetched, captured and written as three bytes before the next
// fetch; there is no overlap between pixels.
// Optional macro BMP_BODY_BYTE_COUNT_EN exposes byte_count from the write port.
module bmp_body_writer
    import bmp_pkg::*;
#(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int HDR_BYTES = BMP_HDR_BYTES,
    parameter int FB_AW     = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             done,
    output logic             err,
    input  logic [10:0]      xMin,
    input  logic [10:0]      xMax,
    input  logic [10:0]      yMin,
    input  logic [10:0]      yMax,
    output logic             fb_rd_en,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [23:0]      fb_rdata,
    output logic [23:0]      addr,
    output logic             wren,
    output logic [15:0]      wrdata,
    input  logic             wr_wait
`ifdef BMP_BODY_BYTE_COUNT_EN
    ,
    output logic [23:0]      byte_count
`endif
);

    localparam logic [11:0] WIDTH_L  = 12'(WIDTH);
    localparam logic [11:0] HEIGHT_L = 12'(HEIGHT);

    bmp_state_t  state;
    bmp_state_t  state_nxt;

    logic [10:0] x_min;
    logic [10:0] x_max;
    logic [10:0] y_min;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [1:0]  pad_cnt;
    logic [23:0] pix_p1;

    logic        start_ok;
    logic        win_bad;
    logic [10:0] w;
    logic [1:0]  pad;
    logic        last_pix;
    logic        last_row;
    logic        accept;
    logic        wr_req;
    logic [7:0]  wr_byte;

    // A start is only honoured when no job is in flight.
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Window checked on the live inputs at start, before it is latched.
    assign win_bad = (xMin > xMax) || (yMin > yMax) ||
                     ({1'b0, xMax} >= WIDTH_L) || ({1'b0, yMax} >= HEIGHT_L);

    assign w        = x_max - x_min + 11'd1;
    assign pad      = bmp_pad(w);
    assign last_pix = (x_cnt == x_max);
    assign last_row = (y_cnt == y_min);

    // Frame buffer address is only driven during the fetch cycle.
    assign fb_addr = fb_rd_en ? (FB_AW'(y_cnt) * FB_AW'(WIDTH) + FB_AW'(x_cnt))
                              : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The final write of the last row goes straight to
    // DONE so done rises the cycle after that write is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = win_bad ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_nxt = S_CAPT;
            S_CAPT:    state_nxt = S_WR_B;
            S_WR_B:    if (accept) state_nxt = S_WR_G;
            S_WR_G:    if (accept) state_nxt = S_WR_R;
            S_WR_R: begin
                if (accept) begin
                    if (!last_pix) begin
                        state_nxt = S_FETCH;
                    end else if (pad != 2'd0) begin
                        state_nxt = S_PAD;
                    end else begin
                        state_nxt = last_row ? S_DONE : S_ROW_END;
                    end
                end
            end
            S_PAD: begin
                if (accept && (pad_cnt == 2'd1)) begin
                    state_nxt = last_row ? S_DONE : S_ROW_END;
                end
            end
            S_ROW_END: state_nxt = last_row ? S_DONE : S_FETCH;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output decode: read strobe, write request with its byte, and done.
    always_comb begin
        fb_rd_en = 1'b0;
        wr_req   = 1'b0;
        wr_byte  = 8'h00;
        done     = 1'b0;
        case (state)
            S_FETCH: fb_rd_en = 1'b1;
            S_WR_B: begin
                wr_req  = 1'b1;
                wr_byte = pix_p1[7:0];
            end
            S_WR_G: begin
                wr_req  = 1'b1;
                wr_byte = pix_p1[15:8];
            end
            S_WR_R: begin
                wr_req  = 1'b1;
                wr_byte = pix_p1[23:16];
            end
            S_PAD:  wr_req = 1'b1;
            S_DONE: done   = 1'b1;
            default: ;
        endcase
    end

    // Job control: error flag, pixel position and remaining pad bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err     <= 1'b0;
            x_cnt   <= 11'd0;
            y_cnt   <= 11'd0;
            pad_cnt <= 2'd0;
        end else begin
            if (start_ok) begin
                err   <= win_bad;
                x_cnt <= xMin;
                y_cnt <= yMax;
            end else if ((state == S_WR_R) && accept && !last_pix) begin
                x_cnt <= x_cnt + 11'd1;
            end else if ((state == S_ROW_END) && !last_row) begin
                x_cnt <= x_min;
                y_cnt <= y_cnt - 11'd1;
            end
            if ((state == S_WR_R) && accept) begin
                pad_cnt <= pad;
            end else if ((state == S_PAD) && accept) begin
                pad_cnt <= pad_cnt - 2'd1;
            end
        end
    end

    // Window bounds held for the whole job.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            x_min <= xMin;
            x_max <= xMax;
            y_min <= yMin;
        end
    end

    // Pixel capture: read data arrives the cycle after the fetch strobe.
    always_ff @(posedge clk) begin
        if (state == S_CAPT) begin
            pix_p1 <= fb_rdata;
        end
    end

    bmp_byte_wr #(
        .HDR_BYTES (HDR_BYTES)
    ) u_byte_wr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_ok),
        .wr_req     (wr_req),
        .wr_byte    (wr_byte),
        .wr_wait    (wr_wait),
        .accept     (accept),
        .addr       (addr),
        .wren       (wren),
        .wrdata     (wrdata)
`ifdef BMP_BODY_BYTE_COUNT_EN
        ,
        .byte_count (byte_count)
`endif
    );

endmodule

// File: doc/bmp_body_writer.md
Name: bmp_body_writer

Overview:
- Downstream neighbour of the BMP header stage. Once the 54-byte header is in output memory, this block copies the crop window xMin..xMax, yMin..yMax out of the RGB frame buffer and writes it as the BMP pixel array.
- Byte order is BGR. Rows are written bottom-up, and each row is zero-padded to a 4-byte boundary.
- Writes go to the same 24-bit byte-addressed output memory as the header, starting at HDR_BYTES.

Parameters:
- WIDTH, 320, frame buffer width in pixels (row stride).
- HEIGHT, 240, frame buffer height in pixels.
- HDR_BYTES, 54, first output address of the pixel array.
- FB_AW, 17, frame buffer address width; must satisfy 2^FB_AW >= WIDTH*HEIGHT.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- done  out  1  high in DONE until the next accepted start
- err  out  1  window invalid; valid while done=1
- xMin, xMax  in  11 each  crop columns, inclusive; must be stable from start until done
- yMin, yMax  in  11 each  crop rows, inclusive; must be stable from start until done
- fb_rd_en  out  1  frame buffer read strobe
- fb_addr  out  FB_AW  frame buffer pixel address = y*WIDTH + x
- fb_rdata  in  24  {R[23:16], G[15:8], B[7:0]}; valid exactly 1 cycle after fb_rd_en
- addr  out  24  output byte address
- wren  out  1  output write enable
- wrdata  out  16  output byte in [7:0]; [15:8] is always 0
- wr_wait  in  1  memory stall; while high with wren=1, hold addr, wren and wrdata unchanged

Behaviour:
- Reset: synchronous, active-low on rst_n, clock clk. All outputs are 0 and the state is IDLE. Reset mid-image aborts immediately: no further writes, no partial done.
- Derived values:
  - w = xMax-xMin+1
  - pad = w & 3 (equals (4 - 3w mod 4) mod 4)
  - row bytes = 3w + pad
- Byte address counter: 24 bits, loaded with HDR_BYTES on start, incremented after every write that is not stalled.
- States:
  - IDLE: on start, latch the window. If xMin>xMax, yMin>yMax, xMax>=WIDTH or yMax>=HEIGHT, go to DONE with err=1 and no writes. Otherwise set y=yMax, x=xMin, err=0, and go to FETCH.
  - FETCH: fb_rd_en=1, fb_addr=y*WIDTH+x. Go to CAPT.
  - CAPT: register fb_rdata. Go to WR_B.
  - WR_B, WR_G, WR_R: wren=1, wrdata={8'h00, byte}. Each advances only when wr_wait=0. After WR_R:
    - if x<xMax: x++ and go to FETCH;
    - else if pad!=0: go to PAD;
    - else go to ROW_END.
  - PAD: write 8'h00, once per pad byte (pad times), stall-aware. Then go to ROW_END.
  - ROW_END: if y==yMin, go to DONE; otherwise y--, x=xMin, and go to FETCH.
  - DONE: done=1 and wren=0. A start re-enters the IDLE start logic in the same cycle.
- Timing:
  - Per pixel: 5 cycles with no stall. No pipelining across pixels.
  - Per row: an extra pad + 1 cycles.
  - done rises the cycle after the last write is accepted.
- start is ignored in any state other than IDLE or DONE.
- Single-pixel window (w=1, one row): writes 3 pixel bytes and 1 pad byte.
- The address counter wraps modulo 2^24; no check is made.
- fb_addr multiply width: 11 x log2(WIDTH); the result is truncated to FB_AW bits.

Optional Feature:
- Macro: BMP_BODY_BYTE_COUNT_EN.
- With the macro defined: adds output byte_count [23:0]. It is cleared on start and incremented on every accepted write, including pad bytes, and holds its value in DONE. It must equal header area = (3w+pad)*(yMax-yMin+1).
- Without the macro: the port does not exist and there is no counter logic.

Decomposition:
- Package bmp_pkg holds:
  - the state enum typedef;
  - BMP_HDR_BYTES = 54 and BMP_ROW_ALIGN = 4;
  - function bmp_pad(w) returning w & 3, shared with the header stage's size computation.
- One sub-module is natural: bmp_byte_wr. It is the stall-aware single-byte write port that owns the address counter, addr/wren/wrdata and byte_count.

Test Plan:
- Window x 0..1, y 0..0; fb[0]=0x112233, fb[1]=0x445566 -> addresses 54..61 receive 33,22,11,66,55,44,00,00; done the cycle after the address-61 write; err=0.
- Window x 5..7, y 0..1; w=3, pad=3 -> the first fb_addr is 325 (row 1 first). Row 1 occupies addresses 54..65 with 65..63 as zeros. Row 0 starts at 66 with fb_addr 5. Total 24 writes.
- wr_wait held high for 3 cycles during the WR_G write -> addr, wren and wrdata are stable for those cycles. No byte is lost or duplicated; the final contents match the no-stall run.
- xMin=10, xMax=4 -> DONE within 2 cycles, err=1, wren never asserted, fb_rd_en never asserted.
- rst_n low for 1 cycle mid-row 0 -> wren=0 and done=0 next cycle. A following start writes again from address 54.
- With BMP_BODY_BYTE_COUNT_EN, window x 0..2, y 0..3 -> byte_count = 48 at done.
